branch_predict_unit: RTL and testbench

// - Next-generation branch address unit: per-cycle fetch-side next-PC prediction plus resolve-side target calc.
// - Fetch side: direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
// - Resolve side: computes branch_addr (PC- or register-relative), detects mispredicts, trains the BTB.
// - Sits between fetch (consumes npc) and execute (supplies resolved outcome); issues a registered redirect.

---
 rtl/branch_pkg.sv | 36 +++
 rtl/btb_table.sv | 60 ++++++
 rtl/branch_predict_unit.sv | 118 +++++++++++
 tb/tb_branch_predict_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch prediction unit.
package branch_pkg;

    localparam int WORD_SIZE = 32;
    localparam int ENTRIES   = 16;
    localparam int IDX_BITS  = $clog2(ENTRIES);
    localparam int TAG_BITS  = WORD_SIZE - IDX_BITS - 2;

    typedef enum logic {
        ADDR_PC = 1'b0,
        ADDR_RD = 1'b1
    } addr_mode_e;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic [TAG_BITS-1:0]  tag;
        logic [WORD_SIZE-1:0] target;
        ctr_t                 ctr;
    } btb_entry_t;

    // Saturating 2-bit counter step toward the observed outcome.
    function automatic ctr_t ctr_step(input ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'b01);
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'b01);
    endfunction

endpackage

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: register array with a fetch read port, a
// resolve-side read port for read-modify-write training, and one write port.
module btb_table
    import branch_pkg::*;
#(
    parameter int Entries = ENTRIES,
    parameter int IdxBits = $clog2(Entries)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [IdxBits-1:0] rd_idx,
    output btb_entry_t         rd_entry,
    input  logic [IdxBits-1:0] rt_idx,
    output btb_entry_t         rt_entry,
    input  logic               wr_en,
    input  logic [IdxBits-1:0] wr_idx,
    input  btb_entry_t         wr_entry
);

    logic                 valid_reg  [Entries];
    ctr_t                 ctr_reg    [Entries];
    logic [TAG_BITS-1:0]  tag_reg    [Entries];
    logic [WORD_SIZE-1:0] target_reg [Entries];
    btb_entry_t           entry_view [Entries];

    // Present each slot as a packed entry so both read ports are plain muxes.
    for (genvar gi = 0; gi < Entries; gi++) begin : g_view
        assign entry_view[gi] = '{valid:  valid_reg[gi],
                                  tag:    tag_reg[gi],
                                  target: target_reg[gi],
                                  ctr:    ctr_reg[gi]};
    end

    assign rd_entry = entry_view[rd_idx];
    assign rt_entry = entry_view[rt_idx];

    // Valid bits and counters: reset wins over a same-cycle write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Entries; i++) begin
            if (!rstn) begin
                valid_reg[i] <= 1'b0;
                ctr_reg[i]   <= CTR_WNT;
            end else if (wr_en && wr_idx == IdxBits'(i)) begin
                valid_reg[i] <= wr_entry.valid;
                ctr_reg[i]   <= wr_entry.ctr;
            end
        end
    end

    // Tag and target are only meaningful behind a valid bit, so no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < Entries; i++) begin
            if (rstn && wr_en && wr_idx == IdxBits'(i)) begin
                tag_reg[i]    <= wr_entry.tag;
                target_reg[i] <= wr_entry.target;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch address unit: fetch-side BTB next-PC prediction, resolve-side
// target calculation, mispredict detection, BTB training and redirect.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int WordSize = WORD_SIZE,
    parameter int Entries  = ENTRIES
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                f_valid,
    input  logic [WordSize-1:0] f_pc,
    output logic                pred_taken,
    output logic [WordSize-1:0] pred_target,
    output logic [WordSize-1:0] npc,
    input  logic                r_valid,
    input  logic                r_is_branch,
    input  logic                r_is_jump,
    input  logic                addr_mode,
    input  logic                branch_taken,
    input  logic [WordSize-1:0] imm,
    input  logic [WordSize-1:0] rs1d,
    input  logic [WordSize-1:0] r_pc,
    input  logic                r_pred_taken,
    input  logic [WordSize-1:0] r_pred_target,
    output logic [WordSize-1:0] branch_addr,
    output logic                redirect,
    output logic [WordSize-1:0] redirect_pc
);

    localparam int IdxBits = $clog2(Entries);

    logic [IdxBits-1:0]  f_idx, r_idx;
    logic [TAG_BITS-1:0] f_tag, r_tag;
    btb_entry_t          f_entry, r_entry, wr_entry;
    logic                f_hit, r_hit, is_cf, taken, mispredict, wr_en;
    logic [WordSize-1:0] correct_pc;
    logic                redirect_reg;
    logic [WordSize-1:0] redirect_pc_reg;

    assign f_idx = f_pc[IdxBits+1:2];
    assign f_tag = f_pc[WordSize-1:IdxBits+2];
    assign r_idx = r_pc[IdxBits+1:2];
    assign r_tag = r_pc[WordSize-1:IdxBits+2];

    btb_table #(
        .Entries (Entries),
        .IdxBits (IdxBits)
    ) u_btb (
        .clk      (clk),
        .rstn     (rstn),
        .rd_idx   (f_idx),
        .rd_entry (f_entry),
        .rt_idx   (r_idx),
        .rt_entry (r_entry),
        .wr_en    (wr_en),
        .wr_idx   (r_idx),
        .wr_entry (wr_entry)
    );

    // Fetch lookup against the registered table (pre-write view).
    always_comb begin
        f_hit       = f_valid & f_entry.valid & (f_entry.tag == f_tag);
        pred_taken  = f_hit & f_entry.ctr[1];
        pred_target = pred_taken ? f_entry.target : '0;
        npc         = pred_taken ? pred_target : f_pc + WordSize'(4);
    end

    // Resolve: target calculation, outcome and mispredict compare.
    always_comb begin
        if (addr_mode_e'(addr_mode) == ADDR_RD) begin
            branch_addr = (rs1d + imm) & ~WordSize'(1);
        end else begin
            branch_addr = r_pc + imm;
        end
        is_cf      = r_is_branch | r_is_jump;
        taken      = r_is_jump | (r_is_branch & branch_taken);
        correct_pc = taken ? branch_addr : r_pc + WordSize'(4);
        mispredict = r_valid & is_cf &
                     ((taken != r_pred_taken) |
                      (taken & (r_pred_target != branch_addr)));
    end

    // Training: allocate on taken miss, update counter/target on hit.
    // A jump (including jump+branch) always forces strongly-taken.
    always_comb begin
        r_hit    = r_entry.valid & (r_entry.tag == r_tag);
        wr_en    = r_valid & is_cf & (r_hit | taken);
        wr_entry = '{valid:  1'b1,
                     tag:    r_tag,
                     target: taken ? branch_addr : r_entry.target,
                     ctr:    r_entry.ctr};
        if (r_is_jump) begin
            wr_entry.ctr = CTR_ST;
        end else if (r_hit) begin
            wr_entry.ctr = ctr_step(r_entry.ctr, taken);
        end else begin
            wr_entry.ctr = CTR_WT;
        end
    end

    // Redirect pulse and held correct PC, one cycle after resolve.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            redirect_reg <= mispredict;
            if (mispredict) begin
                redirect_pc_reg <= correct_pc;
            end
        end
    end

    assign redirect    = redirect_reg;
    assign redirect_pc = redirect_pc_reg;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: stimulus queues expected values tagged with the cycle
// they are due; a negedge monitor compares whatever is due that cycle.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] npc;
    logic        r_valid, r_is_branch, r_is_jump, addr_mode, branch_taken;
    logic [31:0] imm, rs1d, r_pc;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic [31:0] branch_addr;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    branch_predict_unit #(.WordSize(32), .Entries(16)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .f_valid       (f_valid),
        .f_pc          (f_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .npc           (npc),
        .r_valid       (r_valid),
        .r_is_branch   (r_is_branch),
        .r_is_jump     (r_is_jump),
        .addr_mode     (addr_mode),
        .branch_taken  (branch_taken),
        .imm           (imm),
        .rs1d          (rs1d),
        .r_pc          (r_pc),
        .r_pred_taken  (r_pred_taken),
        .r_pred_target (r_pred_target),
        .branch_addr   (branch_addr),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    localparam int S_PT = 0, S_PTG = 1, S_NPC = 2, S_BA = 3, S_RD = 4, S_RDPC = 5;

    exp_t sb[$];
    int   cyc    = 0;
    int   passed = 0;
    int   total  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            S_PT:    return {31'd0, pred_taken};
            S_PTG:   return pred_target;
            S_NPC:   return npc;
            S_BA:    return branch_addr;
            S_RD:    return {31'd0, redirect};
            default: return redirect_pc;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                total++;
                if (actual(sb[i].sig) === sb[i].val) begin
                    passed++;
                    $display("check %-22s cyc=%0d got=0x%08h ok", sb[i].name, cyc, actual(sb[i].sig));
                end else begin
                    $display("FAIL %s cyc=%0d got=0x%08h expected=0x%08h",
                             sb[i].name, cyc, actual(sb[i].sig), sb[i].val);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                total++;
                $display("FAIL %s missed (due cyc=%0d) got=none expected=0x%08h",
                         sb[i].name, sb[i].cyc, sb[i].val);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expc(input int sig, input logic [31:0] v, input string n);
        sb.push_back('{cyc, sig, v, n});
    endtask

    task automatic expr(input int sig, input logic [31:0] v, input string n);
        sb.push_back('{cyc + 1, sig, v, n});
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc);
        f_valid = v;
        f_pc    = pc;
    endtask

    task automatic idle();
        r_valid     = 1'b0;
        r_is_branch = 1'b0;
        r_is_jump   = 1'b0;
    endtask

    task automatic res(input logic br, input logic jp, input logic md, input logic tk,
                       input logic [31:0] im, input logic [31:0] rs, input logic [31:0] pc,
                       input logic pt, input logic [31:0] ptg);
        r_valid       = 1'b1;
        r_is_branch   = br;
        r_is_jump     = jp;
        addr_mode     = md;
        branch_taken  = tk;
        imm           = im;
        rs1d          = rs;
        r_pc          = pc;
        r_pred_taken  = pt;
        r_pred_target = ptg;
    endtask

    task automatic pred(input logic pt, input logic [31:0] tg, input logic [31:0] np, input string n);
        expc(S_PT,  {31'd0, pt}, {n, "_pt"});
        expc(S_PTG, tg,          {n, "_ptg"});
        expc(S_NPC, np,          {n, "_npc"});
    endtask

    task automatic redir(input logic r, input logic [31:0] pc, input string n);
        expr(S_RD,   {31'd0, r}, {n, "_redirect"});
        expr(S_RDPC, pc,         {n, "_redirect_pc"});
    endtask

    initial begin
        rstn = 1'b0;
        fetch(1'b0, 32'h0);
        res(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
        idle();
        tick();
        tick();
        expc(S_RD, 32'd0, "rst_redirect");
        expc(S_RDPC, 32'd0, "rst_redirect_pc");

        tick(); rstn = 1'b1; fetch(1'b1, 32'h100);
        pred(1'b0, 32'h0, 32'h104, "reset_lookup");

        // First taken branch: allocate, same-cycle lookup still misses.
        tick(); res(1, 0, 0, 1, 32'h40, 32'h0, 32'h100, 0, 32'h0);
        expc(S_BA, 32'h140, "ba_pc_rel");
        pred(1'b0, 32'h0, 32'h104, "prewrite_lookup");
        redir(1'b1, 32'h140, "first_alloc");

        // Counter walk 10 -> 01 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10.
        tick(); res(1, 0, 0, 0, 32'h40, 32'h0, 32'h100, 1, 32'h140);
        pred(1'b1, 32'h140, 32'h140, "alloc_hit");
        redir(1'b1, 32'h104, "nt_mispredict");

        tick(); res(1, 0, 0, 0, 32'h40, 32'h0, 32'h100, 0, 32'h0);
        pred(1'b0, 32'h0, 32'h104, "ctr01");
        redir(1'b0, 32'h104, "nt_correct_hold");

        tick(); res(1, 0, 0, 1, 32'h40, 32'h0, 32'h100, 0, 32'h0);
        pred(1'b0, 32'h0, 32'h104, "ctr00");
        redir(1'b1, 32'h140, "t_from_00");

        tick(); res(1, 0, 0, 1, 32'h40, 32'h0, 32'h100, 0, 32'h0);
        pred(1'b0, 32'h0, 32'h104, "ctr01_no_realloc");
        redir(1'b1, 32'h140, "back_to_back");

        tick(); res(1, 0, 0, 1, 32'h40, 32'h0, 32'h100, 1, 32'h140);
        pred(1'b1, 32'h140, 32'h140, "ctr10");
        redir(1'b0, 32'h140, "correct_taken_a");

        tick(); res(1, 0, 0, 1, 32'h40, 32'h0, 32'h100, 1, 32'h140);
        pred(1'b1, 32'h140, 32'h140, "ctr11");
        redir(1'b0, 32'h140, "correct_taken_b");

        tick(); res(1, 0, 0, 0, 32'h40, 32'h0, 32'h100, 1, 32'h140);
        pred(1'b1, 32'h140, 32'h140, "ctr11_sat");
        redir(1'b1, 32'h104, "nt_from_11");

        // Register-relative jump with wrong predicted target.
        tick(); res(0, 1, 1, 0, 32'h10, 32'h2001, 32'h204, 1, 32'h3000);
        expc(S_BA, 32'h2010, "ba_rd_rel");
        pred(1'b1, 32'h140, 32'h140, "ctr10_after_sat");
        redir(1'b1, 32'h2010, "wrong_target");

        tick(); idle(); fetch(1'b1, 32'h204);
        pred(1'b1, 32'h2010, 32'h2010, "jump_alloc");
        expr(S_RD, 32'd0, "idle_redirect");

        // Alias at index 0: 0x140 evicts 0x100.
        tick(); res(1, 0, 0, 1, 32'h20, 32'h0, 32'h140, 0, 32'h0); fetch(1'b1, 32'h100);
        expc(S_BA, 32'h160, "ba_alias");
        pred(1'b1, 32'h140, 32'h140, "alias_prewrite");
        redir(1'b1, 32'h160, "alias_alloc");

        tick(); idle(); fetch(1'b1, 32'h100);
        pred(1'b0, 32'h0, 32'h104, "alias_evicted");

        tick(); fetch(1'b1, 32'h140);
        pred(1'b1, 32'h160, 32'h160, "alias_new");

        tick(); fetch(1'b0, 32'h140);
        pred(1'b0, 32'h0, 32'h144, "fvalid_low");

        // Wrap, then reset during a training/mispredicting cycle.
        tick(); fetch(1'b1, 32'hFFFF_FFFC); rstn = 1'b0;
        res(1, 0, 0, 1, 32'h8, 32'h0, 32'h208, 0, 32'h0);
        pred(1'b0, 32'h0, 32'h0, "wrap");
        redir(1'b0, 32'h0, "reset_dominates");

        tick(); rstn = 1'b1; idle(); fetch(1'b1, 32'h208);
        pred(1'b0, 32'h0, 32'h20C, "reset_no_write");

        tick(); fetch(1'b1, 32'h204);
        pred(1'b0, 32'h0, 32'h208, "reset_clears_jump");

        tick(); fetch(1'b1, 32'h140);
        res(1, 0, 0, 1, 32'h8, 32'h0, 32'h300, 0, 32'h0); r_valid = 1'b0;
        pred(1'b0, 32'h0, 32'h144, "reset_clears_alias");
        expr(S_RD, 32'd0, "rvalid_low_redirect");

        tick(); idle(); fetch(1'b1, 32'h300);
        pred(1'b0, 32'h0, 32'h304, "rvalid_low_no_train");

        for (int k = 0; k < 20 && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            total += sb.size();
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
